// File: rtl/rom_wr_ctrl.sv
// ============================================================================
// Module   : rom_wr_ctrl
// Brief    : Write-side initiator for the byte-wide CE_bar/OE_bar/WE_bar bus.
//            Requests are queued in a FIFO and replayed as timed write strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_wr_ctrl #(
    parameter int ADDR_WD    = 8,
    parameter int DATA_WD    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int T_SETUP    = 1,
    parameter int T_PULSE    = 2,
    parameter int T_HOLD     = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_req_vld,
    output logic               wr_req_rdy,
    input  logic [ADDR_WD-1:0] wr_req_addr,
    input  logic [DATA_WD-1:0] wr_req_data,
    input  logic               rd_bus_active,
    output logic               wr_bus_req,
    output logic [ADDR_WD-1:0] mem_wr_addr,
    output logic [DATA_WD-1:0] mem_wr_data,
    output logic               CE_bar,
    output logic               OE_bar,
    output logic               WE_bar,
    output logic               wr_done,
    output logic [15:0]        wr_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = ADDR_WD + DATA_WD;
    localparam int T_MAX = (T_SETUP > T_PULSE) ?
                           ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD) :
                           ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
    localparam int PH_W  = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [PH_W-1:0]  c_ph_setup = PH_W'(T_SETUP - 1);
    localparam logic [PH_W-1:0]  c_ph_pulse = PH_W'(T_PULSE - 1);
    localparam logic [PH_W-1:0]  c_ph_hold  = PH_W'(T_HOLD - 1);
    localparam logic [PTR_W:0]   c_full_cnt = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [PH_W-1:0]  r_phase;
    logic [PH_W-1:0]  w_phase_nxt;
    logic             w_ph_done;
    logic             w_finish;

    assign w_full     = (r_count == c_full_cnt);
    assign w_empty    = (r_count == '0);
    assign w_push     = wr_req_vld & ~w_full;
    // The reader is only consulted before a strobe starts; never mid-write.
    assign w_pop      = (r_state == ST_IDLE) & ~w_empty & ~rd_bus_active;
    assign w_head     = r_fifo_mem[r_rd_ptr];

    assign wr_req_rdy = ~w_full;
    assign wr_bus_req = ~w_empty | (r_state != ST_IDLE);
    assign OE_bar     = 1'b1;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= {wr_req_addr, wr_req_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Strobe sequencer; phase counter counts down from T_x-1 to 0
    // ------------------------------------------------------------------
    assign w_ph_done = (r_phase == '0);
    assign w_finish  = (r_state == ST_HOLD) & w_ph_done;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_nxt = ST_SETUP;
                    w_phase_nxt = c_ph_setup;
                end
            end
            ST_SETUP: begin
                if (w_ph_done) begin
                    w_state_nxt = ST_PULSE;
                    w_phase_nxt = c_ph_pulse;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            ST_PULSE: begin
                if (w_ph_done) begin
                    w_state_nxt = ST_HOLD;
                    w_phase_nxt = c_ph_hold;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (w_ph_done) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase - PH_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Strobes are flopped from the next state so they never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            CE_bar      <= 1'b1;
            WE_bar      <= 1'b1;
            wr_done     <= 1'b0;
            wr_cnt      <= 16'd0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            CE_bar  <= (w_state_nxt == ST_IDLE);
            WE_bar  <= (w_state_nxt != ST_PULSE);
            wr_done <= w_finish;
            if (w_finish) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (w_pop) begin
                mem_wr_addr <= w_head[ENT_W-1:DATA_WD];
                mem_wr_data <= w_head[DATA_WD-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_wr_ctrl.sv
// ============================================================================
// Module   : tb_rom_wr_ctrl
// Brief    : Directed vector table plus multi-cycle sequences for rom_wr_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_wr_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_req_vld;
    logic        wr_req_rdy;
    logic [7:0]  wr_req_addr;
    logic [7:0]  wr_req_data;
    logic        rd_bus_active;
    logic        wr_bus_req;
    logic [7:0]  mem_wr_addr;
    logic [7:0]  mem_wr_data;
    logic        CE_bar;
    logic        OE_bar;
    logic        WE_bar;
    logic        wr_done;
    logic [15:0] wr_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    rom_wr_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_req_vld   (wr_req_vld),
        .wr_req_rdy   (wr_req_rdy),
        .wr_req_addr  (wr_req_addr),
        .wr_req_data  (wr_req_data),
        .rd_bus_active(rd_bus_active),
        .wr_bus_req   (wr_bus_req),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .CE_bar       (CE_bar),
        .OE_bar       (OE_bar),
        .WE_bar       (WE_bar),
        .wr_done      (wr_done),
        .wr_cnt       (wr_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        vld;
        logic [7:0]  a;
        logic [7:0]  d;
        logic        rd;
        logic        rdy;
        logic        breq;
        logic        ce;
        logic        we;
        logic        done;
        logic [15:0] cnt;
        logic [7:0]  ma;
        logic [7:0]  md;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic vld, logic [7:0] a, logic [7:0] d, logic rd,
                                logic rdy, logic breq, logic ce, logic we, logic done,
                                logic [15:0] cnt, logic [7:0] ma, logic [7:0] md);
        vec_t v;
        v.vld = vld; v.a = a; v.d = d; v.rd = rd;
        v.rdy = rdy; v.breq = breq; v.ce = ce; v.we = we; v.done = done;
        v.cnt = cnt; v.ma = ma; v.md = md;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wr_done === 1'b1) seen = 1;
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: wr_done timeout got 0 expected 1", name);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        wr_req_vld    = 1'b0;
        wr_req_addr   = 8'h00;
        wr_req_data   = 8'h00;
        rd_bus_active = 1'b0;

        // Single write, then a write whose strobe overlaps a reader request.
        tbl[0]  = mk(1, 8'h05, 8'hA5, 0,  1, 0, 1, 1, 0, 16'd0, 8'h00, 8'h00);
        tbl[1]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 1, 1, 0, 16'd0, 8'h00, 8'h00);
        tbl[2]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 0, 1, 0, 16'd0, 8'h05, 8'hA5);
        tbl[3]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 0, 0, 0, 16'd0, 8'h05, 8'hA5);
        tbl[4]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 0, 0, 0, 16'd0, 8'h05, 8'hA5);
        tbl[5]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 0, 1, 0, 16'd0, 8'h05, 8'hA5);
        tbl[6]  = mk(0, 8'h00, 8'h00, 0,  1, 0, 1, 1, 1, 16'd1, 8'h05, 8'hA5);
        tbl[7]  = mk(0, 8'h00, 8'h00, 0,  1, 0, 1, 1, 0, 16'd1, 8'h05, 8'hA5);
        tbl[8]  = mk(1, 8'h22, 8'h5C, 0,  1, 0, 1, 1, 0, 16'd1, 8'h05, 8'hA5);
        tbl[9]  = mk(0, 8'h00, 8'h00, 0,  1, 1, 1, 1, 0, 16'd1, 8'h05, 8'hA5);
        tbl[10] = mk(0, 8'h00, 8'h00, 0,  1, 1, 0, 1, 0, 16'd1, 8'h22, 8'h5C);
        tbl[11] = mk(0, 8'h00, 8'h00, 1,  1, 1, 0, 0, 0, 16'd1, 8'h22, 8'h5C);
        tbl[12] = mk(0, 8'h00, 8'h00, 1,  1, 1, 0, 0, 0, 16'd1, 8'h22, 8'h5C);
        tbl[13] = mk(0, 8'h00, 8'h00, 1,  1, 1, 0, 1, 0, 16'd1, 8'h22, 8'h5C);
        tbl[14] = mk(0, 8'h00, 8'h00, 1,  1, 0, 1, 1, 1, 16'd2, 8'h22, 8'h5C);
        tbl[15] = mk(0, 8'h00, 8'h00, 0,  1, 0, 1, 1, 0, 16'd2, 8'h22, 8'h5C);

        repeat (2) @(negedge clk);
        chk("reset_state", {27'd0, CE_bar, WE_bar, OE_bar, wr_done, wr_bus_req},
            {27'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("reset_cnt_addr", {wr_cnt, mem_wr_addr, mem_wr_data}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr_req_vld    = tbl[i].vld;
            wr_req_addr   = tbl[i].a;
            wr_req_data   = tbl[i].d;
            rd_bus_active = tbl[i].rd;
            n_vec++;
            if ({wr_req_rdy, wr_bus_req, CE_bar, WE_bar, OE_bar, wr_done, wr_cnt, mem_wr_addr, mem_wr_data} !==
                {tbl[i].rdy, tbl[i].breq, tbl[i].ce, tbl[i].we, 1'b1, tbl[i].done, tbl[i].cnt, tbl[i].ma, tbl[i].md}) begin
                n_err++;
                $display("FAIL vec%0d: got rdy=%b breq=%b ce=%b we=%b oe=%b done=%b cnt=%0d a=%h d=%h expected rdy=%b breq=%b ce=%b we=%b oe=1 done=%b cnt=%0d a=%h d=%h",
                         i, wr_req_rdy, wr_bus_req, CE_bar, WE_bar, OE_bar, wr_done, wr_cnt, mem_wr_addr, mem_wr_data,
                         tbl[i].rdy, tbl[i].breq, tbl[i].ce, tbl[i].we, tbl[i].done, tbl[i].cnt, tbl[i].ma, tbl[i].md);
            end
        end

        // Burst of six: FIFO fills, writes drain in order every 5 cycles.
        fork
            begin
                int  k = 0;
                bit  saw_low = 0;
                int  guard = 0;
                while (k < 6 && guard < 100) begin
                    @(negedge clk);
                    guard++;
                    if (wr_req_rdy) begin
                        wr_req_vld  = 1'b1;
                        wr_req_addr = 8'h10 + 8'(k);
                        wr_req_data = 8'hC0 + 8'(k);
                        k++;
                    end else begin
                        wr_req_vld = 1'b0;
                        saw_low    = 1;
                    end
                end
                @(negedge clk);
                wr_req_vld = 1'b0;
                chk("burst_rdy_low", {31'd0, saw_low}, 32'd1);
            end
            begin
                int last = 0;
                for (int j = 0; j < 6; j++) begin
                    wait_done("burst_done");
                    chk("burst_addr", {16'd0, mem_wr_addr, mem_wr_data},
                        {16'd0, 8'h10 + 8'(j), 8'hC0 + 8'(j)});
                    chk("burst_cnt", {16'd0, wr_cnt}, 32'd3 + 32'(j));
                    chk("burst_gap_ce", {31'd0, CE_bar}, 32'd1);
                    if (j > 0) chk("burst_period", cyc - last, 32'd5);
                    last = cyc;
                end
            end
        join
        @(negedge clk);
        chk("burst_drained", {31'd0, wr_bus_req}, 32'd0);

        // Reader holds the bus for 20 cycles with two writes pending.
        begin
            int viol = 0;
            @(negedge clk);
            rd_bus_active = 1'b1;
            wr_req_vld = 1'b1; wr_req_addr = 8'h40; wr_req_data = 8'h11;
            @(negedge clk);
            wr_req_addr = 8'h41; wr_req_data = 8'h22;
            @(negedge clk);
            wr_req_vld = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (CE_bar !== 1'b1 || wr_bus_req !== 1'b1) viol++;
            end
            chk("arb_hold", viol, 32'd0);
            rd_bus_active = 1'b0;
            @(negedge clk);
            chk("arb_start_ce", {31'd0, CE_bar}, 32'd0);
            chk("arb_start_addr", {24'd0, mem_wr_addr}, 32'h40);
            wait_done("arb_done1");
            chk("arb_cnt1", {16'd0, wr_cnt}, 32'd9);
            wait_done("arb_done2");
            chk("arb_second", {wr_cnt, mem_wr_addr, mem_wr_data}, {16'd10, 8'h41, 8'h22});
        end

        // Reset asserted mid-strobe with three entries still queued.
        begin
            int bad = 0;
            bit seen_we = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                wr_req_vld = 1'b1;
                wr_req_addr = 8'h50 + 8'(i);
                wr_req_data = 8'h70 + 8'(i);
            end
            @(negedge clk);
            wr_req_vld = 1'b0;
            for (int i = 0; i < 10 && !seen_we; i++) begin
                if (WE_bar === 1'b0) seen_we = 1;
                else @(negedge clk);
            end
            chk("rst_reached_pulse", {31'd0, seen_we}, 32'd1);
            #1 reset_n = 1'b0;
            #1;
            chk("rst_async_strobe", {30'd0, CE_bar, WE_bar}, 32'd3);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (12) begin
                @(negedge clk);
                if (CE_bar !== 1'b1 || wr_done !== 1'b0 || wr_bus_req !== 1'b0) bad++;
            end
            chk("rst_no_write", bad, 32'd0);
            chk("rst_cnt", {15'd0, wr_req_rdy, wr_cnt}, {15'd0, 1'b1, 16'd0});
        end

        // Counter wrap: preload near the top, then two writes.
        @(negedge clk);
        force dut.wr_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.wr_cnt;
        @(negedge clk);
        wr_req_vld = 1'b1; wr_req_addr = 8'hE0; wr_req_data = 8'h01;
        @(negedge clk);
        wr_req_addr = 8'hE1; wr_req_data = 8'h02;
        @(negedge clk);
        wr_req_vld = 1'b0;
        wait_done("wrap_done1");
        chk("wrap_ffff", {16'd0, wr_cnt}, 32'h0000FFFF);
        wait_done("wrap_done2");
        chk("wrap_zero", {15'd0, wr_done, wr_cnt}, {15'd0, 1'b1, 16'h0000});
        chk("wrap_data", {16'd0, mem_wr_addr, mem_wr_data}, {16'd0, 8'hE1, 8'h02});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
